// File: rtl/pcm_adc_rx.sv
// Master-mode stereo ADC receiver (I2S or left-justified) generating BCK/LRCK from clk.
// Optional peak meters (peak_l, peak_r, peak_clr) are compiled in with `define PCM_ADC_RX_PEAK_EN.
module pcm_adc_rx #(
  parameter int w_sample  = 24,
  parameter int slot_bits = 32,
  parameter int bck_div   = 4,
  parameter int i2s_mode  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                bck,
  output logic                lrck,
  input  logic                dout,
  output logic [w_sample-1:0] left,
  output logic [w_sample-1:0] right,
  output logic                valid,
  input  logic                ready,
  output logic                overrun,
`ifdef PCM_ADC_RX_PEAK_EN
  output logic [w_sample-2:0] peak_l,
  output logic [w_sample-2:0] peak_r,
  input  logic                peak_clr,
`endif
  output logic                busy
);

  localparam int BIT_W  = $clog2(2 * slot_bits);
  localparam int DIV_W  = (bck_div > 2) ? $clog2(bck_div) : 1;
  localparam int CAP_LO = (i2s_mode != 0) ? 1 : 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]          state;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    slot_k;
  logic [BIT_W-1:0]    cap_idx;
  logic                tick, rise, fall, frame_end, capture, last_bit;
  logic [w_sample-1:0] shift_reg;
  logic [w_sample-1:0] stage;
  logic                load_pend;

  assign busy      = (state != IDLE);
  assign tick      = busy && (div_cnt == DIV_W'(bck_div - 1));
  assign rise      = tick && !bck;
  assign fall      = tick && bck;
  assign frame_end = fall && (bit_cnt == BIT_W'(2 * slot_bits - 1));
  assign lrck      = (bit_cnt >= BIT_W'(slot_bits));
  assign slot_k    = lrck ? bit_cnt - BIT_W'(slot_bits) : bit_cnt;
  // Index relative to the MSB position; slot bits before it wrap to a large value and are skipped.
  assign cap_idx   = slot_k - BIT_W'(CAP_LO);
  assign capture   = rise && (cap_idx < BIT_W'(w_sample));
  assign last_bit  = capture && (cap_idx == BIT_W'(w_sample - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= STOP;
        STOP:    if (enable) state <= RUN;
                 else if (frame_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A stop lands exactly on the last falling toggle, so the wrap leaves the counters at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      bit_cnt <= '0;
    end else if (!busy) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        bck     <= !bck;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall) bit_cnt <= frame_end ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  // NOTE: non-blocking assignments let stage read the pre-shift value of shift_reg in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      stage     <= '0;
      load_pend <= 1'b0;
    end else begin
      load_pend <= last_bit && lrck;
      if (capture) shift_reg <= {shift_reg[w_sample-2:0], dout};
      if (last_bit && !lrck) stage <= {shift_reg[w_sample-2:0], dout};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left    <= '0;
      right   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load_pend && valid && !ready;
      if (load_pend) begin
        left  <= stage;
        right <= shift_reg;
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef PCM_ADC_RX_PEAK_EN
  function automatic logic [w_sample-2:0] mag(input logic [w_sample-1:0] s);
    if (!s[w_sample-1])               return s[w_sample-2:0];
    else if (s[w_sample-2:0] == '0)   return '1;
    else                              return ~s[w_sample-2:0] + (w_sample-1)'(1);
  endfunction

  logic [w_sample-2:0] mag_l, mag_r;
  assign mag_l = mag(stage);
  assign mag_r = mag(shift_reg);

  // A pair loading together with peak_clr restarts the meter from the new magnitude.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_l <= '0;
      peak_r <= '0;
    end else if (load_pend) begin
      peak_l <= (peak_clr || mag_l > peak_l) ? mag_l : peak_l;
      peak_r <= (peak_clr || mag_r > peak_r) ? mag_r : peak_r;
    end else if (peak_clr) begin
      peak_l <= '0;
      peak_r <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pcm_adc_rx.sv
// Bench for pcm_adc_rx: an LJ and an I2S instance share stimulus and are checked every cycle
// against a frame-level model driven by the bench's own run-cycle count.
`timescale 1ns/1ps
module tb_pcm_adc_rx;
  localparam int W     = 24;
  localparam int SLOT  = 32;
  localparam int BD    = 4;
  localparam int BCK_P = 2 * BD;
  localparam int FRAME = 2 * SLOT * BCK_P;

  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, ready = 1'b0;
  logic dout [2];
  logic bck [2], lrck [2], valid [2], overrun [2], busy [2];
  logic [W-1:0] left [2], right [2];
`ifdef PCM_ADC_RX_PEAK_EN
  logic peak_clr = 1'b0;
  logic [W-2:0] peak_l [2], peak_r [2];
  logic [W-2:0] exp_pl [2], exp_pr [2];
`endif

  int n_checks = 0, n_errors = 0;
  string nm [2] = '{"lj", "i2s"};

  // model state
  int run_c = -1;
  logic stop_req = 1'b0;
  logic exp_valid [2], exp_over [2];
  logic [W-1:0] exp_left [2], exp_right [2];
  logic [W-1:0] fl [16], fr [16];
  int m_fi;

  // observed events
  int cyc = 0, start_cyc = 0, fall_at = -1;
  int rise_at [2], over_cnt [2];
  int bck_rise [2], lrck_rise [2];
  int nb_bck = 0, nb_lr = 0;
  logic pv [2], pbck = 1'b0, plr = 1'b0, pbusy = 1'b0;
  int d_j, d_k;
  logic [W-1:0] d_s;

  always #5 clk = ~clk;

  pcm_adc_rx #(.w_sample(W), .slot_bits(SLOT), .bck_div(BD), .i2s_mode(0)) u_lj (
    .clk(clk), .rst(rst), .enable(enable), .bck(bck[0]), .lrck(lrck[0]), .dout(dout[0]),
    .left(left[0]), .right(right[0]), .valid(valid[0]), .ready(ready), .overrun(overrun[0]),
`ifdef PCM_ADC_RX_PEAK_EN
    .peak_l(peak_l[0]), .peak_r(peak_r[0]), .peak_clr(peak_clr),
`endif
    .busy(busy[0]));

  pcm_adc_rx #(.w_sample(W), .slot_bits(SLOT), .bck_div(BD), .i2s_mode(1)) u_i2s (
    .clk(clk), .rst(rst), .enable(enable), .bck(bck[1]), .lrck(lrck[1]), .dout(dout[1]),
    .left(left[1]), .right(right[1]), .valid(valid[1]), .ready(ready), .overrun(overrun[1]),
`ifdef PCM_ADC_RX_PEAK_EN
    .peak_l(peak_l[1]), .peak_r(peak_r[1]), .peak_clr(peak_clr),
`endif
    .busy(busy[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle within the frame during which the last right bit is sampled; the pair loads at its end.
  function automatic int load_cycle(input int i2s);
    return BCK_P * (SLOT + W + i2s) - BD;
  endfunction

`ifdef PCM_ADC_RX_PEAK_EN
  function automatic logic [W-2:0] magnitude(input logic [W-1:0] s);
    longint v;
    logic [63:0] r;
    v = s[W-1] ? longint'(s) - (longint'(1) << W) : longint'(s);
    if (v < 0) v = -v;
    if (v > (longint'(1) << (W-1)) - 1) v = (longint'(1) << (W-1)) - 1;
    r = v;
    return r[W-2:0];
  endfunction
`endif

  // Frame-level model: position in the run, pair loads at fixed frame offsets, handshake rules.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      run_c = -1;
      stop_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
        exp_valid[i] = 1'b0; exp_over[i] = 1'b0; exp_left[i] = '0; exp_right[i] = '0;
`ifdef PCM_ADC_RX_PEAK_EN
        exp_pl[i] = '0; exp_pr[i] = '0;
`endif
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (run_c >= 0 && run_c % FRAME == load_cycle(i)) begin
          m_fi = (run_c / FRAME) % 16;
          exp_over[i]  = exp_valid[i] && !ready;
          exp_valid[i] = 1'b1;
          exp_left[i]  = fl[m_fi];
          exp_right[i] = fr[m_fi];
`ifdef PCM_ADC_RX_PEAK_EN
          if (peak_clr || magnitude(fl[m_fi]) > exp_pl[i]) exp_pl[i] = magnitude(fl[m_fi]);
          if (peak_clr || magnitude(fr[m_fi]) > exp_pr[i]) exp_pr[i] = magnitude(fr[m_fi]);
`endif
        end else begin
          exp_over[i] = 1'b0;
          if (ready) exp_valid[i] = 1'b0;
`ifdef PCM_ADC_RX_PEAK_EN
          if (peak_clr) begin exp_pl[i] = '0; exp_pr[i] = '0; end
`endif
        end
      end
      if (run_c < 0) begin
        if (enable) begin run_c = 0; stop_req = 1'b0; end
      end else if (enable) begin
        stop_req = 1'b0; run_c++;
      end else if (stop_req && run_c % FRAME == FRAME - 1) begin
        run_c = -1;
      end else begin
        stop_req = 1'b1; run_c++;
      end
    end
  end

  // Compare every cycle on the falling edge, log events, then present this cycle's ADC bit.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (run_c == 0) begin
      start_cyc = cyc; nb_bck = 0; nb_lr = 0;
      for (int i = 0; i < 2; i++) begin rise_at[i] = -1; over_cnt[i] = 0; end
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.bck", nm[i]), bck[i], run_c >= 0 && run_c % BCK_P >= BD);
      check($sformatf("%s.lrck", nm[i]), lrck[i], run_c >= 0 && run_c % FRAME >= FRAME / 2);
      check($sformatf("%s.busy", nm[i]), busy[i], run_c >= 0);
      check($sformatf("%s.valid", nm[i]), valid[i], exp_valid[i]);
      check($sformatf("%s.overrun", nm[i]), overrun[i], exp_over[i]);
      check($sformatf("%s.left", nm[i]), left[i], exp_left[i]);
      check($sformatf("%s.right", nm[i]), right[i], exp_right[i]);
`ifdef PCM_ADC_RX_PEAK_EN
      check($sformatf("%s.peak_l", nm[i]), peak_l[i], exp_pl[i]);
      check($sformatf("%s.peak_r", nm[i]), peak_r[i], exp_pr[i]);
`endif
      if (valid[i] && !pv[i]) rise_at[i] = run_c;
      if (overrun[i]) over_cnt[i]++;
      pv[i] = valid[i];
    end
    if (bck[0] && !pbck && nb_bck < 2) begin bck_rise[nb_bck] = run_c; nb_bck++; end
    if (lrck[0] && !plr && nb_lr < 2) begin lrck_rise[nb_lr] = run_c; nb_lr++; end
    if (!busy[0] && pbusy) fall_at = cyc - start_cyc;
    pbck = bck[0]; plr = lrck[0]; pbusy = busy[0];
    for (int i = 0; i < 2; i++) begin
      dout[i] = 1'($urandom_range(0, 1));
      if (run_c >= 0) begin
        d_j = (run_c % FRAME) / BCK_P;
        d_k = d_j % SLOT;
        d_s = (d_j >= SLOT) ? fr[(run_c / FRAME) % 16] : fl[(run_c / FRAME) % 16];
        if (d_k >= i && d_k < W + i) dout[i] = d_s[W - 1 - (d_k - i)];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic goto_run(input int c);
    logic found = 1'b0;
    for (int n = 0; n < 8000 && !found; n++) begin
      @(negedge clk);
      if (run_c == c) found = 1'b1;
    end
    check($sformatf("reach run cycle %0d", c), found, 1'b1);
    #2;
  endtask

  task automatic wait_idle();
    logic found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      @(negedge clk);
      if (run_c < 0) found = 1'b1;
    end
    check("reach idle", found, 1'b1);
    #2;
  endtask

  task automatic fill_tables();
    for (int f = 0; f < 16; f++) begin
      fl[f] = W'($urandom);
      fr[f] = W'($urandom);
    end
  endtask

  initial begin
    dout[0] = 1'b0; dout[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin pv[i] = 1'b0; rise_at[i] = -1; over_cnt[i] = 0; end
    fill_tables();
    #1 rst = 1'b1;
    step(3);
    for (int i = 0; i < 2; i++) begin
      check("reset bck", bck[i], 1'b0);
      check("reset valid", valid[i], 1'b0);
      check("reset left", left[i], 24'h0);
    end
    rst = 1'b0;
    step(2);

    // Run 1: known pair, two unaccepted frames, then random handshake, stop mid-frame 4.
    fl[0] = 24'h123456; fr[0] = 24'hABCDEF;
    ready = 1'b0; enable = 1'b1;
    goto_run(446);
    check("lj first left", left[0], 24'h123456);
    check("lj first right", right[0], 24'hABCDEF);
    check("lj valid rise cycle", rise_at[0], 445);
    check("bck first rise", bck_rise[0], 4);
    check("bck period", bck_rise[1] - bck_rise[0], 8);
    goto_run(454);
    check("i2s first left", left[1], 24'h123456);
    check("i2s first right", right[1], 24'hABCDEF);
    check("i2s valid rise cycle", rise_at[1], 453);
    goto_run(FRAME + 460);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s overrun pulses", nm[i]), over_cnt[i], 1);
      check($sformatf("%s second left", nm[i]), left[i], fl[1]);
    end
    check("lrck period", lrck_rise[1] - lrck_rise[0], FRAME);
    ready = 1'b1;
    step(1);
    check("lj valid cleared", valid[0], 1'b0);
    check("i2s valid cleared", valid[1], 1'b0);
    while (run_c >= 0 && run_c < 4 * FRAME + 100) begin
      if ($urandom_range(0, 199) == 0) ready = !ready;
      step(1);
    end
    enable = 1'b0;
    wait_idle();
    check("run1 busy fall cycle", fall_at, 5 * FRAME);

    // Run 2: enable dropped at cycle 100; the frame still completes.
    step(20);
    check("idle bck", bck[0], 1'b0);
    check("idle lrck", lrck[0], 1'b0);
    fill_tables();
    ready = 1'b1; enable = 1'b1;
    goto_run(100);
    enable = 1'b0;
    wait_idle();
    check("run2 busy fall cycle", fall_at, 512);
    check("run2 lj valid", rise_at[0], 445);
    check("run2 i2s valid", rise_at[1], 453);
    step(20);

    // Run 3: reset in the middle of the first frame.
    fill_tables();
    enable = 1'b1;
    goto_run(300);
    rst = 1'b1; enable = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst busy", busy[i], 1'b0);
      check("rst bck", bck[i], 1'b0);
      check("rst lrck", lrck[i], 1'b0);
      check("rst right", right[i], 24'h0);
    end
    step(2);
    rst = 1'b0;
    step(600);
    check("no valid after abort lj", valid[0], 1'b0);
    check("no valid after abort i2s", valid[1], 1'b0);

`ifdef PCM_ADC_RX_PEAK_EN
    // Run 4: most negative sample saturates the meter, then clear.
    fill_tables();
    fl[0] = 24'h800000; fl[1] = 24'h000010;
    ready = 1'b1; enable = 1'b1;
    goto_run(FRAME + 460);
    check("lj peak_l sat", peak_l[0], 23'h7FFFFF);
    check("i2s peak_l sat", peak_l[1], 23'h7FFFFF);
    peak_clr = 1'b1;
    step(1);
    peak_clr = 1'b0;
    check("lj peak_l clr", peak_l[0], 23'h0);
    check("i2s peak_l clr", peak_l[1], 23'h0);
    enable = 1'b0;
    wait_idle();
`endif

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pcm_adc_rx.md
# pcm_adc_rx

Parametrised master-mode serial audio ADC receiver for PCM1801/PCM1808-class converters. It replaces the fixed-format receiver and the ad-hoc LRCK-edge capture that sit in each board top. The block runs entirely in the system clock domain and generates BCK and LRCK from `clk` by an integer divider. It deserialises a stereo frame in I2S or left-justified format and presents each completed left/right pair on a valid/ready handshake with overrun reporting. It sits between the board ADC pins and `top`'s `mic` input.

## Interface
- `w_sample`, 24: captured bits per channel, 8..32, MSB first.
- `slot_bits`, 32: BCK periods per channel slot; must be ≥ `w_sample` (+1 in I2S mode).
- `bck_div`, 4: `clk` cycles per BCK half-period, ≥ 2.
- `i2s_mode`, 0: 0 = left-justified (MSB in first BCK of slot); 1 = I2S (MSB in second BCK of slot).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run request.
- `bck` out 1: bit clock to ADC.
- `lrck` out 1: frame clock; 0 = left slot, 1 = right slot.
- `dout` in 1: ADC serial data.
- `left` out `w_sample`: left sample, two's complement.
- `right` out `w_sample`: right sample, two's complement.
- `valid` out 1: pair available.
- `ready` in 1: consumer accepts the pair.
- `overrun` out 1: one-cycle pulse; an unaccepted pair was overwritten.
- `busy` out 1: FSM not in IDLE.
- `peak_l`, `peak_r` out `w_sample`-1: present only with `PCM_ADC_RX_PEAK_EN`.
- `peak_clr` in 1: present only with `PCM_ADC_RX_PEAK_EN`.

## Operation
- FSM states:
  - IDLE: `bck`=0, `lrck`=0, counters zero; `enable`=1 → RUN.
  - RUN: `enable`=0 → STOP.
  - STOP: completes the current frame, then → IDLE; `enable`=1 in STOP → RUN without interrupting the frame.
- Divider `div_cnt` counts 0..`bck_div`-1; `bck` toggles when `div_cnt`=`bck_div`-1.
- `bit_cnt` counts 0..2·`slot_bits`-1 and advances on each BCK falling toggle.
- `lrck` = (`bit_cnt` ≥ `slot_bits`), so it changes only on BCK falling toggles.
- Capture: `dout` is shifted in during the `clk` cycle in which `bck` toggles 0→1.
  - Slot bit index k = `bit_cnt` mod `slot_bits`.
  - Captured k is 0..`w_sample`-1 in LJ mode and 1..`w_sample` in I2S mode; all other bits are ignored.
- After the last left bit, the left shift register is copied to a staging register.
- After the last right bit, `left` ← staging and `right` ← shift register in the same cycle, and `valid` is set.
- Handshake:
  - `valid` holds until a cycle with `valid`&`ready`, then clears next cycle.
  - A new pair arriving while `valid`=1 and not accepted in that cycle overwrites the pair, keeps `valid`=1 and pulses `overrun`.
  - Accept and new pair in the same cycle: the new pair is loaded, `valid` stays 1, no overrun.
- The first frame output after leaving IDLE is the first full frame; there are no partial frames.
- `rst` mid-frame: all state returns to reset values immediately and the in-flight frame is discarded.

## Timing
- Reset values: `bck`=0, `lrck`=0, `left`=0, `right`=0, `valid`=0, `overrun`=0, `busy`=0, peaks 0.
- Cycle 0 is the first RUN cycle.
- BCK rising edge n (1-based within the frame) occurs at cycle 2·`bck_div`·n − `bck_div`.
- Frame length: 2·`slot_bits`·2·`bck_div` clk; with the defaults this is 512.
- `valid` rises one cycle after the capture of the last right bit.
- Handshake-to-clear latency is 1 cycle. `overrun` is registered and asserts in the load cycle +1.

## Configuration
- `PCM_ADC_RX_PEAK_EN` defined:
  - Adds `peak_l`/`peak_r`: the running maximum of |sample| per channel, updated when a pair loads.
  - |most negative| saturates to 2^(`w_sample`-1)-1.
  - `peak_clr` zeroes both peaks next cycle. A load in the same cycle as `peak_clr` wins: the peak takes the new |sample|.
- Undefined: the ports and logic are absent; all other behaviour is identical.

## Test plan
- LJ mode, defaults; model drives left=24'h123456, right=24'hABCDEF:
  - `left`/`right` match; `valid` rises at cycle 8·56−4+1=445.
  - `lrck` period 512 clk; `bck` period 8 clk.
- I2S mode, same data → identical values; `valid` rises at cycle 8·57−4+1=453.
- `ready`=0 for two frames:
  - `overrun` pulses once, at the second load.
  - Outputs show the second frame's data; `ready`=1 then clears `valid` after 1 cycle.
- `enable` dropped at cycle 100:
  - The frame still completes and yields `valid`.
  - `busy` falls at cycle 512; `bck`/`lrck` are held at 0 afterwards.
- `rst` pulsed at cycle 300 → all outputs return to 0 asynchronously; no `valid` for the aborted frame.
- With `PCM_ADC_RX_PEAK_EN`: frames of left=24'h800000 then 24'h000010 → `peak_l`=23'h7FFFFF; `peak_clr` → 0.
